// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic ops, iterative multiply and divide.
// Ports: clk/rst, in_valid/in_ready request side, out_valid/out_ready result side, result/result_hi/comp/flags/div_zero/illegal.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             comp,
  output logic [3:0]       flags,
  output logic             div_zero,
  output logic             illegal
);

  localparam int W   = WIDTH;
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_NOT  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SLA  = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;
  localparam logic [4:0] OP_EQ   = 5'd10;
  localparam logic [4:0] OP_GT   = 5'd11;
  localparam logic [4:0] OP_GTU  = 5'd12;
  localparam logic [4:0] OP_GE   = 5'd13;
  localparam logic [4:0] OP_LE   = 5'd14;
  localparam logic [4:0] OP_GEU  = 5'd15;
  localparam logic [4:0] OP_LEU  = 5'd16;
  localparam logic [4:0] OP_BSL  = 5'd17;
  localparam logic [4:0] OP_MUL  = 5'd18;
  localparam logic [4:0] OP_MULU = 5'd19;
  localparam logic [4:0] OP_DIV  = 5'd20;
  localparam logic [4:0] OP_DIVU = 5'd21;
  localparam logic [4:0] OP_REM  = 5'd22;
  localparam logic [4:0] OP_REMU = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [SHW-1:0] cnt_q, cnt_d;
  logic [4:0]     op_q, op_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   a_q, a_d;
  logic           neg_q, neg_d;

  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   result_hi_q, result_hi_d;
  logic           comp_q, comp_d;
  logic [3:0]     flags_q, flags_d;
  logic           div_zero_q, div_zero_d;
  logic           illegal_q, illegal_d;

  // Single-cycle datapath on the live request operands
  logic [W:0]     add_w, sub_w;
  logic [SHW-1:0] sh;
  logic [W-1:0]   sc_res;
  logic           sc_comp, sc_c, sc_v;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign sh    = b[SHW-1:0];

  always_comb begin
    sc_res  = '0;
    sc_comp = 1'b0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_w[W-1:0];
        sc_c   = add_w[W];
        sc_v   = (a[W-1] == b[W-1]) &&
                 (add_w[W-1] != a[W-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[W-1:0];
        sc_c   = sub_w[W];
        sc_v   = (a[W-1] != b[W-1]) &&
                 (sub_w[W-1] != a[W-1]);
      end
      OP_NOT:         sc_res = ~a;
      OP_AND:         sc_res = a & b;
      OP_OR:          sc_res = a | b;
      OP_XOR:         sc_res = a ^ b;
      OP_SLL, OP_SLA: sc_res = a << sh;
      OP_SRL:         sc_res = a >> sh;
      OP_SRA:         sc_res = $signed(a) >>> sh;
      OP_EQ:          sc_comp = (a == b);
      OP_GT:          sc_comp = ($signed(a) > $signed(b));
      OP_GTU:         sc_comp = (a > b);
      OP_GE:          sc_comp = ($signed(a) >= $signed(b));
      OP_LE:          sc_comp = ($signed(a) <= $signed(b));
      OP_GEU:         sc_comp = (a >= b);
      OP_LEU:         sc_comp = (a <= b);
      OP_BSL:         sc_res = b << (W / 2);
      default: ;
    endcase
  end

  // Request classification and operand magnitudes
  logic         req_mul, req_div, req_ill, req_sgn, req_rem;
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  assign req_mul = (op == OP_MUL) || (op == OP_MULU);
  assign req_div = (op == OP_DIV) || (op == OP_DIVU) ||
                   (op == OP_REM) || (op == OP_REMU);
  assign req_ill = (op[4:3] == 2'b11);
  assign req_sgn = (op == OP_MUL) || (op == OP_DIV) ||
                   (op == OP_REM);
  assign req_rem = (op == OP_REM) || (op == OP_REMU);
  assign a_neg   = req_sgn & a[W-1];
  assign b_neg   = req_sgn & b[W-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;

  // One shift-add step: acc = {partial high, remaining multiplier}
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt, prod;

  assign mul_sum = {1'b0, acc_q[2*W-1:W]} +
                   (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[W-1:1]};
  assign prod    = neg_q ? -mul_nxt : mul_nxt;

  // One restoring step: acc = {partial remainder, dividend/quotient}
  logic [W:0]     div_sh, div_df;
  logic           div_ok;
  logic [2*W-1:0] div_nxt;
  logic           q_rem, q_dz;
  logic [W-1:0]   dval, dres;

  assign div_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_df  = div_sh - {1'b0, opb_q};
  // Remainder stays below the divisor, so bit W is a clean borrow
  assign div_ok  = !div_df[W];
  assign div_nxt = div_ok ?
    {div_df[W-1:0], acc_q[W-2:0], 1'b1} :
    {div_sh[W-1:0], acc_q[W-2:0], 1'b0};

  assign q_rem = (op_q == OP_REM) || (op_q == OP_REMU);
  assign q_dz  = (opb_q == '0);
  assign dval  = q_rem ? div_nxt[2*W-1:W] : div_nxt[W-1:0];

  always_comb begin
    dres = neg_q ? -dval : dval;
    if (q_dz) dres = q_rem ? a_q : '1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    a_d         = a_q;
    neg_d       = neg_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    comp_d      = comp_q;
    flags_d     = flags_q;
    div_zero_d  = div_zero_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          a_d   = a;
          cnt_d = '0;
          acc_d = {{W{1'b0}}, a_mag};
          opb_d = b_mag;
          neg_d = (req_rem & ~req_mul) ? a_neg
                                       : (a_neg ^ b_neg);
          if (req_mul) begin
            state_d = S_MUL;
          end else if (req_div) begin
            state_d = S_DIV;
          end else begin
            state_d     = S_DONE;
            result_d    = req_ill ? '0 : sc_res;
            result_hi_d = '0;
            comp_d      = req_ill ? 1'b0 : sc_comp;
            flags_d     = req_ill ? 4'b0 :
              {sc_res == '0, sc_res[W-1], sc_c, sc_v};
            div_zero_d  = 1'b0;
            illegal_d   = req_ill;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(W - 1)) begin
          state_d     = S_DONE;
          result_d    = prod[W-1:0];
          result_hi_d = prod[2*W-1:W];
          comp_d      = 1'b0;
          flags_d     = {prod == '0, prod[2*W-1], 2'b00};
          div_zero_d  = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      S_DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(W - 1)) begin
          state_d     = S_DONE;
          result_d    = dres;
          result_hi_d = '0;
          comp_d      = 1'b0;
          flags_d     = {dres == '0, dres[W-1], 2'b00};
          div_zero_d  = q_dz;
          illegal_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      a_q         <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      comp_q      <= 1'b0;
      flags_q     <= '0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      a_q         <= a_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      comp_q      <= comp_d;
      flags_q     <= flags_d;
      div_zero_q  <= div_zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign comp      = comp_q;
  assign flags     = flags_q;
  assign div_zero  = div_zero_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Adds valid/ready handshakes, registered results, status flags, an iterative multiplier (full 2*WIDTH product) and an iterative divider (quotient/remainder, signed and unsigned).
- Sits in the execute stage. The control unit stalls the pipeline on `in_ready`/`out_valid`.

Parameters:
- WIDTH, 16, operand/result width; even, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- op  input  5  operation code (table below)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes result
- result  output  WIDTH  primary result (low product / quotient / remainder)
- result_hi  output  WIDTH  high product half; 0 for other ops
- comp  output  1  comparison result
- flags  output  4  {Z,N,C,V}
- div_zero  output  1  divide/remainder by zero occurred
- illegal  output  1  op code 24..31

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 NOT(a), 3 AND, 4 OR, 5 XOR
  - 6 SLL, 7 SRL, 8 SLA (= SLL), 9 SRA
  - 10 EQ, 11 GT, 12 GTU, 13 GE, 14 LE, 15 GEU, 16 LEU
  - 17 BSL = b << (WIDTH/2)
  - 18 MUL (signed x signed), 19 MULU
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - 24-31 illegal
- Signedness: EQ/GT/GE/LE are signed two's complement; GTU/GEU/LEU are unsigned.
- Shifts: amount = b[SHW-1:0]; upper bits of b are ignored.
- States: IDLE, MUL, DIV, DONE.
- Acceptance:
  - `in_ready` = 1 only in IDLE.
  - Accept on `in_valid && in_ready` at edge T.
  - a, b and op are captured at T; later input changes are ignored.
- Single-cycle ops (0-17, 24-31): IDLE -> DONE at T; `out_valid` = 1 from T+1.
- MUL/MULU:
  - Radix-2 shift-add over WIDTH iterations. IDLE -> MUL at T; MUL -> DONE after WIDTH cycles; `out_valid` from T+WIDTH+1.
  - Signed MUL uses operand magnitudes and a sign fix on the final product.
  - `result_hi:result` = full 2*WIDTH product.
- DIV/DIVU/REM/REMU:
  - Restoring division over WIDTH iterations; same timing as MUL (`out_valid` from T+WIDTH+1).
  - Signed variants divide magnitudes. Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Divide by zero (b == 0):
  - DIV/DIVU give quotient all-ones; REM/REMU give remainder = a.
  - `div_zero` = 1.
  - No early exit; latency unchanged.
- Signed overflow: DIV with a = MIN, b = -1 gives quotient MIN; REM gives 0. `div_zero` = 0.
- DONE:
  - Outputs are held stable while `out_ready` = 0.
  - The cycle `out_valid && out_ready` is seen, the next state is IDLE and `out_valid` drops the following cycle.
  - Throughput is one single-cycle op per 2 cycles when `out_ready` = 1.
- Output values by op class:
  - Non-comparison ops: `comp` = 0.
  - Comparison ops: `result` = 0 and `result_hi` = 0.
  - Illegal ops: `result` = 0, `comp` = 0, `flags` = 0, `illegal` = 1.
- Flags:
  - Z = (result == 0) for all legal ops. For MUL/MULU, Z = (result_hi:result == 0).
  - N = result[WIDTH-1]; for MUL/MULU, N = result_hi[WIDTH-1].
  - C: ADD = carry out; SUB = borrow (a < b unsigned); 0 otherwise.
  - V: signed overflow for ADD/SUB only; 0 otherwise.
- Reset:
  - While `rst` = 1 at an edge: state = IDLE, in-flight operation abandoned.
  - All outputs 0 except `in_ready`, which = 1 from the cycle after reset.
  - Reset mid-MUL/DIV discards the partial result; no `out_valid` is produced for it.
- All outputs are registered or decoded from state; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=16, ADD a=0x7FFF b=0x0001, out_ready=1 -> `out_valid` at T+1, result=0x8000, flags Z0 N1 C0 V1; `in_ready` back at T+2.
- MUL a=0xFFFF (-1) b=0x0003 -> `out_valid` exactly at T+17, result=0xFFFD, result_hi=0xFFFF; MULU on the same operands -> result_hi=0x0002, result=0xFFFD.
- DIV a=0xFFF9 (-7) b=0x0002 -> quotient 0xFFFD (-3); REM on the same operands -> 0xFFFF (-1); DIVU 100/0 -> result=0xFFFF, `div_zero`=1; DIV 0x8000/0xFFFF -> 0x8000, `div_zero`=0.
- Compares: GT a=0xFFFF b=0x0001 -> comp=0; GTU on the same operands -> comp=1; EQ 0x1234/0x1234 -> comp=1, result=0.
- Backpressure: out_ready=0 for 5 cycles after SRA a=0x8000 b=0x0013 (amount 3) -> result=0xF000 held stable, `in_ready`=0 throughout; result released on the first cycle out_ready=1.
- Reset at T+5 of a DIVU -> next cycle: `out_valid`=0, `in_ready`=1, all outputs 0; op=25 -> `illegal`=1, result=0.
